vga_timing_driver: RTL

VGA_TIMING_DRIVER -- requirements
Module: vga_timing_driver

---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_timing_driver.sv | 107 ++++++++++
 2 files changed

// File: rtl/vga_timing_pkg.sv
// VGA timing package: 640x480@60 default timings and RGB565 colour
// constants shared between the timing driver and pixel-source blocks.
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam int H_SYNC_DEF  = 96;
    localparam int H_BACK_DEF  = 48;
    localparam int H_DISP_DEF  = 640;
    localparam int H_FRONT_DEF = 16;
    localparam int H_TOTAL_DEF = H_SYNC_DEF + H_BACK_DEF
                               + H_DISP_DEF + H_FRONT_DEF;

    // Vertical timing, in lines
    localparam int V_SYNC_DEF  = 2;
    localparam int V_BACK_DEF  = 33;
    localparam int V_DISP_DEF  = 480;
    localparam int V_FRONT_DEF = 10;
    localparam int V_TOTAL_DEF = V_SYNC_DEF + V_BACK_DEF
                               + V_DISP_DEF + V_FRONT_DEF;

    // Pixel clocks in one full frame
    localparam int FRAME_CYCLES_DEF = H_TOTAL_DEF * V_TOTAL_DEF;

    // RGB565 colour constants
    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] BLUE  = 16'h001F;
    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] GREEN = 16'h07E0;

    // Pack 5/6/5-bit components into one RGB565 word
    function automatic logic [15:0] rgb565(
        input logic [4:0] r,
        input logic [5:0] g,
        input logic [4:0] b
    );
        return {r, g, b};
    endfunction

endpackage

// File: rtl/vga_timing_driver.sv
// VGA timing driver: horizontal/vertical counters with sync, pixel
// request and active-video decode; pixel data returns one cycle later.
module vga_timing_driver
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BACK  = H_BACK_DEF,
    parameter int H_DISP  = H_DISP_DEF,
    parameter int H_FRONT = H_FRONT_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BACK  = V_BACK_DEF,
    parameter int V_DISP  = V_DISP_DEF,
    parameter int V_FRONT = V_FRONT_DEF
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [15:0] pixel_data,
    output logic [9:0]  pixel_xpos,
    output logic [9:0]  pixel_ypos,
    output logic        data_req,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        video_en,
    output logic [15:0] vga_rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    // Counter terminal values
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Sync pulse widths
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);

    // Active video window
    localparam logic [9:0] H_ACT_BEG = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_END = 10'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [9:0] V_ACT_BEG = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_END = 10'(V_SYNC + V_BACK + V_DISP - 1);

    // Request window sits one pixel clock ahead of the active window
    localparam logic [9:0] H_REQ_BEG = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_REQ_END = 10'(H_SYNC + H_BACK + H_DISP - 2);

    logic [9:0] h_cnt_q;
    logic [9:0] h_cnt_d;
    logic [9:0] v_cnt_q;
    logic [9:0] v_cnt_d;

    logic       h_wrap;
    logic       v_wrap;
    logic       h_in_act;
    logic       h_in_req;
    logic       v_in_act;

    // Next-state for the pixel and line counters; both wrap together
    // on the last pixel of the last line
    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    // Counter registers, cleared asynchronously by reset
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= 10'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Window decode from the current counter values
    always_comb begin
        h_in_act = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q <= H_ACT_END);
        h_in_req = (h_cnt_q >= H_REQ_BEG) && (h_cnt_q <= H_REQ_END);
        v_in_act = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q <= V_ACT_END);
    end

    // Sync, request, position and video output decode; positions are
    // only subtracted inside the request window so they never underflow
    always_comb begin
        vga_hs      = (h_cnt_q >= H_SYNC_W);
        vga_vs      = (v_cnt_q >= V_SYNC_W);
        video_en    = h_in_act && v_in_act;
        data_req    = h_in_req && v_in_act;
        frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        pixel_xpos  = 10'd0;
        pixel_ypos  = 10'd0;
        if (data_req) begin
            pixel_xpos = h_cnt_q - H_REQ_BEG;
            pixel_ypos = v_cnt_q - V_ACT_BEG;
        end
        vga_rgb = video_en ? pixel_data : BLACK;
    end

endmodule
